// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes and
// datapath select codes.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_IMM_EXEC  = 4'd10,
    S_IMM_WB    = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;

  localparam logic [1:0] ALUB_B       = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_legal(input logic [5:0] op);
    return (op == OP_R)   || (op == OP_LW)   || (op == OP_SW)  || (op == OP_BEQ) ||
           (op == OP_J)   || (op == OP_ADDI) || (op == OP_ORI) || (op == OP_LUI);
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational control-output decode for the multi-cycle controller.
// All outputs are forced low while reset is held so no strobe escapes.
module mc_output_decode
  import mips_mc_pkg::*;
(
  input  state_t      i_state,
  input  logic [5:0]  i_opcode,
  input  logic        i_mem_ready,
  input  logic        i_rstn,
  output logic        o_pc_write,
  output logic        o_pc_write_cond,
  output logic        o_i_or_d,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic        o_ir_write,
  output logic        o_reg_dst,
  output logic        o_mem_to_reg,
  output logic        o_reg_write,
  output logic        o_alu_src_a,
  output logic [1:0]  o_alu_src_b,
  output logic [1:0]  o_alu_op,
  output logic [1:0]  o_pc_source,
  output logic        o_lui_op,
  output logic        o_ori_op,
  output logic        o_instr_done,
  output logic        o_illegal_instr
);

  logic w_is_lui;
  logic w_is_ori;

  assign w_is_lui = (i_opcode == OP_LUI);
  assign w_is_ori = (i_opcode == OP_ORI);

  always_comb begin
    o_pc_write      = 1'b0;
    o_pc_write_cond = 1'b0;
    o_i_or_d        = 1'b0;
    o_mem_read      = 1'b0;
    o_mem_write     = 1'b0;
    o_ir_write      = 1'b0;
    o_reg_dst       = 1'b0;
    o_mem_to_reg    = 1'b0;
    o_reg_write     = 1'b0;
    o_alu_src_a     = 1'b0;
    o_alu_src_b     = ALUB_B;
    o_alu_op        = ALUOP_ADD;
    o_pc_source     = PCSRC_ALU;
    o_lui_op        = 1'b0;
    o_ori_op        = 1'b0;
    o_instr_done    = 1'b0;
    o_illegal_instr = 1'b0;
    if (i_rstn) begin
      case (i_state)
        S_FETCH: begin
          // IR and PC+4 commit only in the cycle memory actually delivers
          o_mem_read  = 1'b1;
          o_alu_src_b = ALUB_FOUR;
          o_ir_write  = i_mem_ready;
          o_pc_write  = i_mem_ready;
        end
        S_DECODE: begin
          o_alu_src_b = ALUB_IMM_SH2;
          if (!is_legal(i_opcode)) begin
            o_illegal_instr = 1'b1;
            o_instr_done    = 1'b1;
          end
        end
        S_MEM_ADDR: begin
          o_alu_src_a = 1'b1;
          o_alu_src_b = ALUB_IMM;
        end
        S_MEM_READ: begin
          o_mem_read = 1'b1;
          o_i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          o_reg_write  = 1'b1;
          o_mem_to_reg = 1'b1;
          o_instr_done = 1'b1;
        end
        S_MEM_WRITE: begin
          o_mem_write  = 1'b1;
          o_i_or_d     = 1'b1;
          o_instr_done = i_mem_ready;
        end
        S_EXECUTE: begin
          o_alu_src_a = 1'b1;
          o_alu_op    = ALUOP_FUNCT;
        end
        S_R_WB: begin
          o_reg_write  = 1'b1;
          o_reg_dst    = 1'b1;
          o_instr_done = 1'b1;
        end
        S_BRANCH: begin
          o_alu_src_a     = 1'b1;
          o_alu_op        = ALUOP_SUB;
          o_pc_write_cond = 1'b1;
          o_pc_source     = PCSRC_ALUOUT;
          o_instr_done    = 1'b1;
        end
        S_JUMP: begin
          o_pc_write   = 1'b1;
          o_pc_source  = PCSRC_JUMP;
          o_instr_done = 1'b1;
        end
        S_IMM_EXEC: begin
          o_alu_src_a = 1'b1;
          o_alu_src_b = ALUB_IMM;
          o_lui_op    = w_is_lui;
          o_ori_op    = w_is_ori;
        end
        S_IMM_WB: begin
          o_reg_write  = 1'b1;
          o_lui_op     = w_is_lui;
          o_ori_op     = w_is_ori;
          o_instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS main controller: state register and next-state logic;
// per-cycle control outputs come from mc_output_decode.
module multi_cycle_control
  import mips_mc_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic        lui_op,
  output logic        ori_op,
  output logic        instr_done,
  output logic        illegal_instr,
  output logic [3:0]  state
);

  state_t r_state;
  state_t w_state_next;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_FETCH;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FETCH:     if (mem_ready) w_state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:           w_state_next = S_MEM_ADDR;
          OP_R:                   w_state_next = S_EXECUTE;
          OP_BEQ:                 w_state_next = S_BRANCH;
          OP_J:                   w_state_next = S_JUMP;
          OP_ADDI, OP_ORI, OP_LUI: w_state_next = S_IMM_EXEC;
          default:                w_state_next = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  w_state_next = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) w_state_next = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) w_state_next = S_FETCH;
      S_EXECUTE:   w_state_next = S_R_WB;
      S_IMM_EXEC:  w_state_next = S_IMM_WB;
      default:     w_state_next = S_FETCH;
    endcase
  end

  assign state = r_state;

  mc_output_decode u_output_decode (
    .i_state         (r_state),
    .i_opcode        (opcode),
    .i_mem_ready     (mem_ready),
    .i_rstn          (rstn),
    .o_pc_write      (pc_write),
    .o_pc_write_cond (pc_write_cond),
    .o_i_or_d        (i_or_d),
    .o_mem_read      (mem_read),
    .o_mem_write     (mem_write),
    .o_ir_write      (ir_write),
    .o_reg_dst       (reg_dst),
    .o_mem_to_reg    (mem_to_reg),
    .o_reg_write     (reg_write),
    .o_alu_src_a     (alu_src_a),
    .o_alu_src_b     (alu_src_b),
    .o_alu_op        (alu_op),
    .o_pc_source     (pc_source),
    .o_lui_op        (lui_op),
    .o_ori_op        (ori_op),
    .o_instr_done    (instr_done),
    .o_illegal_instr (illegal_instr)
  );

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: each instruction is expanded into its
// expected cycle script, played with random memory waits, and compared.
module tb_multi_cycle_control;
  import mips_mc_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic pcw, pcwc, iord, mr, mw, irw, rdst, m2r, rw, asa;
    logic [1:0] asb, aop, psrc;
    logic lui, ori, done, ill;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  logic [5:0] opcode;
  logic mem_ready;
  logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic lui_op, ori_op, instr_done, illegal_instr;
  logic [3:0] state;

  int vectors = 0;
  int miscompares = 0;

  exp_t exp_q[$];
  exp_t obs_q[$];
  logic rdy_q[$];
  logic [5:0] op_q[$];

  exp_t obs;
  assign obs = {state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
                lui_op, ori_op, instr_done, illegal_instr};

  always #5 clk = ~clk;

  multi_cycle_control dut (
    .clk(clk), .rstn(rstn), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .lui_op(lui_op), .ori_op(ori_op),
    .instr_done(instr_done), .illegal_instr(illegal_instr), .state(state)
  );

  function automatic exp_t blank(input state_t s);
    exp_t e;
    e = '0;
    e.st = s;
    return e;
  endfunction

  task automatic clear();
    exp_q.delete(); obs_q.delete(); rdy_q.delete(); op_q.delete();
  endtask

  task automatic add(input exp_t e, input logic rdy, input logic [5:0] op);
    exp_q.push_back(e); rdy_q.push_back(rdy); op_q.push_back(op);
  endtask

  // Expected cycle script of one instruction: fw FETCH waits, mw memory waits.
  // mem_ready is randomised wherever it must be ignored.
  task automatic build(input logic [5:0] op, input int fw, input int mw);
    exp_t e;
    for (int i = 0; i <= fw; i++) begin
      e = blank(S_FETCH); e.mr = 1'b1; e.asb = 2'b01;
      if (i == fw) begin e.irw = 1'b1; e.pcw = 1'b1; end
      add(e, (i == fw), 6'($urandom));
    end
    e = blank(S_DECODE); e.asb = 2'b11;
    case (op)
      6'h23, 6'h2B: begin
        add(e, 1'($urandom), op);
        e = blank(S_MEM_ADDR); e.asa = 1'b1; e.asb = 2'b10;
        add(e, 1'($urandom), op);
        for (int i = 0; i <= mw; i++) begin
          e = blank(op == 6'h23 ? S_MEM_READ : S_MEM_WRITE); e.iord = 1'b1;
          if (op == 6'h23) e.mr = 1'b1;
          else begin e.mw = 1'b1; e.done = (i == mw); end
          add(e, (i == mw), op);
        end
        if (op == 6'h23) begin
          e = blank(S_MEM_WB); e.rw = 1'b1; e.m2r = 1'b1; e.done = 1'b1;
          add(e, 1'($urandom), op);
        end
      end
      6'h00: begin
        add(e, 1'($urandom), op);
        e = blank(S_EXECUTE); e.asa = 1'b1; e.aop = 2'b10;
        add(e, 1'($urandom), op);
        e = blank(S_R_WB); e.rw = 1'b1; e.rdst = 1'b1; e.done = 1'b1;
        add(e, 1'($urandom), op);
      end
      6'h04: begin
        add(e, 1'($urandom), op);
        e = blank(S_BRANCH); e.asa = 1'b1; e.aop = 2'b01; e.pcwc = 1'b1;
        e.psrc = 2'b01; e.done = 1'b1;
        add(e, 1'($urandom), op);
      end
      6'h02: begin
        add(e, 1'($urandom), op);
        e = blank(S_JUMP); e.pcw = 1'b1; e.psrc = 2'b10; e.done = 1'b1;
        add(e, 1'($urandom), op);
      end
      6'h08, 6'h0D, 6'h0F: begin
        add(e, 1'($urandom), op);
        e = blank(S_IMM_EXEC); e.asa = 1'b1; e.asb = 2'b10;
        e.lui = (op == 6'h0F); e.ori = (op == 6'h0D);
        add(e, 1'($urandom), op);
        e = blank(S_IMM_WB); e.rw = 1'b1; e.done = 1'b1;
        e.lui = (op == 6'h0F); e.ori = (op == 6'h0D);
        add(e, 1'($urandom), op);
      end
      default: begin
        e.ill = 1'b1; e.done = 1'b1;
        add(e, 1'($urandom), op);
      end
    endcase
  endtask

  task automatic play(input int n);
    obs_q.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mem_ready = rdy_q[i];
      opcode    = op_q[i];
      #1;
      obs_q.push_back(obs);
    end
  endtask

  task automatic test_reset();
    exp_t e;
    rstn = 1'b0; mem_ready = 1'b0; opcode = 6'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ready = 1'($urandom); opcode = 6'($urandom);
      #1;
      vectors++;
      if (obs !== blank(S_FETCH)) begin
        miscompares++;
        $display("FAIL reset_hold cyc%0d: got %h want %h", i, obs, blank(S_FETCH));
      end
    end
    @(negedge clk);
    rstn = 1'b1; mem_ready = 1'b0;
    #1;
    e = blank(S_FETCH); e.mr = 1'b1; e.asb = 2'b01;
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL reset_release: got %h want %h", obs, e);
    end
    $display("reset: outputs held low, FETCH after release");
  endtask

  task automatic test_rtype();
    int done_at;
    clear(); build(6'h00, 0, 0); play(exp_q.size());
    done_at = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL rtype cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
      if (obs_q[i].done === 1'b1 && done_at < 0) done_at = i + 1;
    end
    vectors++;
    if (done_at !== 4) begin
      miscompares++;
      $display("FAIL rtype_latency: got %0d want 4", done_at);
    end
    $display("rtype: %0d cycles, instr_done at cycle %0d", exp_q.size(), done_at);
  endtask

  task automatic test_lw_waits();
    int done_at, irw_cnt, irw_at;
    clear(); build(6'h23, 3, 2); play(exp_q.size());
    done_at = -1; irw_cnt = 0; irw_at = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL lw cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
      if (obs_q[i].irw === 1'b1) begin irw_cnt++; irw_at = i + 1; end
      if (obs_q[i].done === 1'b1 && done_at < 0) done_at = i + 1;
    end
    vectors++;
    if (irw_cnt !== 1 || irw_at !== 4) begin
      miscompares++;
      $display("FAIL lw_ir_write: got %0d pulses at %0d want 1 at 4", irw_cnt, irw_at);
    end
    vectors++;
    if (done_at !== 10) begin
      miscompares++;
      $display("FAIL lw_latency: got %0d want 10", done_at);
    end
    $display("lw: %0d cycles, instr_done at cycle %0d", exp_q.size(), done_at);
  endtask

  task automatic test_beq();
    int done_at;
    clear(); build(6'h04, 0, 0); play(exp_q.size());
    done_at = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL beq cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
      if (i > 0 && obs_q[i].pcw !== 1'b0) begin
        vectors++; miscompares++;
        $display("FAIL beq_pc_write cyc%0d: got %b want 0", i, obs_q[i].pcw);
      end
      if (obs_q[i].done === 1'b1 && done_at < 0) done_at = i + 1;
    end
    vectors++;
    if (done_at !== 3) begin
      miscompares++;
      $display("FAIL beq_latency: got %0d want 3", done_at);
    end
    $display("beq: %0d cycles, instr_done at cycle %0d", exp_q.size(), done_at);
  endtask

  task automatic test_imm_flags();
    clear(); build(6'h0F, 0, 0); build(6'h0D, 1, 0); build(6'h00, 0, 0);
    play(exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL lui_ori cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    $display("lui+ori+R: %0d cycles", exp_q.size());
  endtask

  task automatic test_illegal();
    int done_at;
    clear(); build(6'h3F, 0, 0); play(exp_q.size());
    done_at = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL illegal cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
      if (obs_q[i].done === 1'b1 && done_at < 0) done_at = i + 1;
    end
    vectors++;
    if (done_at !== 2) begin
      miscompares++;
      $display("FAIL illegal_latency: got %0d want 2", done_at);
    end
    $display("illegal 0x3F: %0d cycles, instr_done at cycle %0d", exp_q.size(), done_at);
  endtask

  task automatic test_reset_mid_write();
    exp_t e;
    clear(); build(6'h2B, 0, 5); play(4);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL sw_pre_reset cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    #2 rstn = 1'b0;
    #1;
    vectors++;
    if (obs !== blank(S_FETCH)) begin
      miscompares++;
      $display("FAIL async_abort: got %h want %h", obs, blank(S_FETCH));
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      mem_ready = 1'($urandom); opcode = 6'($urandom);
      #1;
      vectors++;
      if (obs !== blank(S_FETCH)) begin
        miscompares++;
        $display("FAIL reset_low cyc%0d: got %h want %h", i, obs, blank(S_FETCH));
      end
    end
    @(negedge clk);
    rstn = 1'b1; mem_ready = 1'b0;
    #1;
    e = blank(S_FETCH); e.mr = 1'b1; e.asb = 2'b01;
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL abort_release: got %h want %h", obs, e);
    end
    $display("sw aborted by reset during MEM_WRITE wait");
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [11];
    logic [5:0] op;
    int fw, mw, bad;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h0D, 6'h0F, 6'h3F, 6'h2A, 6'h01};
    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(0, 10)];
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      clear(); build(op, fw, mw); play(exp_q.size());
      bad = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (obs_q[i] !== exp_q[i]) begin
          miscompares++; bad++;
          $display("FAIL b2b#%0d op%02h cyc%0d: got %h want %h", n, op, i, obs_q[i], exp_q[i]);
        end
      end
      $display("b2b#%0d op=%02h fetch_wait=%0d mem_wait=%0d cycles=%0d bad=%0d",
               n, op, fw, mw, exp_q.size(), bad);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_waits();
    test_beq();
    test_imm_flags();
    test_illegal();
    test_reset_mid_write();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
